// File: rtl/field_pkg.sv
// Shared widths, requester ids and the compare-index bit reversal
// for the field lookup scheduler.
package field_pkg;

    localparam int X_BITS       = 10;
    localparam int ACC_BITS     = 11;
    localparam int BUCKET_BITS  = 5;
    localparam int CMP_BITS     = 5;
    localparam int FRAC_BITS    = 2;
    localparam int STARVE_LIMIT = 8;

    localparam logic [1:0] REQ_LINE  = 2'd0;
    localparam logic [1:0] REQ_PIXEL = 2'd1;
    localparam logic [1:0] REQ_BG    = 2'd2;

    function automatic logic [CMP_BITS-1:0] bitrev(input logic [CMP_BITS-1:0] v);
        logic [CMP_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < CMP_BITS; i++) begin
            r[i] = v[CMP_BITS-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/field_rr_arbiter.sv
// Three-way grant: line has fixed priority, pixel/background share a
// round-robin slot, and background is forced through after a starvation wait.
module field_rr_arbiter
    import field_pkg::*;
#(
    parameter int STARVE_LIMIT_P = STARVE_LIMIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic [2:0] req_valid,
    output logic [2:0] grant
);

    localparam int SW = $clog2(STARVE_LIMIT_P + 1);

    logic          r_rr_bg;     // 0: pointer names pixel, 1: names background
    logic [SW-1:0] r_starve;
    logic [2:0]    w_grant;
    logic          w_starved;

    assign w_starved = (r_starve == SW'(STARVE_LIMIT_P));

    always_comb begin
        w_grant = 3'b000;
        if (flush) begin
            w_grant = 3'b000;
        end else if (w_starved && req_valid[REQ_BG]) begin
            w_grant = 3'b100;
        end else if (req_valid[REQ_LINE]) begin
            w_grant = 3'b001;
        end else if (!r_rr_bg) begin
            if (req_valid[REQ_PIXEL])   w_grant = 3'b010;
            else if (req_valid[REQ_BG]) w_grant = 3'b100;
        end else begin
            if (req_valid[REQ_BG])         w_grant = 3'b100;
            else if (req_valid[REQ_PIXEL]) w_grant = 3'b010;
        end
    end

    assign grant = w_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_bg  <= 1'b0;
            r_starve <= '0;
        end else begin
            if (w_grant[REQ_PIXEL]) begin
                r_rr_bg <= 1'b1;
            end else if (w_grant[REQ_BG]) begin
                r_rr_bg <= 1'b0;
            end

            if (flush || !req_valid[REQ_BG] || w_grant[REQ_BG]) begin
                r_starve <= '0;
            end else if (!w_starved) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

endmodule

// File: rtl/field_lookup_sched.sv
// Time-shares the field table port and accumulate datapath between the
// line, pixel and background requesters; two-edge latency, one per cycle.
module field_lookup_sched
    import field_pkg::*;
#(
    parameter int X_BITS       = field_pkg::X_BITS,
    parameter int ACC_BITS     = field_pkg::ACC_BITS,
    parameter int BUCKET_BITS  = field_pkg::BUCKET_BITS,
    parameter int CMP_BITS     = field_pkg::CMP_BITS,
    parameter int FRAC_BITS    = field_pkg::FRAC_BITS,
    parameter int STARVE_LIMIT = field_pkg::STARVE_LIMIT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [2:0]                    req_valid,
    output logic [2:0]                    req_ready,
    input  logic [3*X_BITS-1:0]           req_coord,
    input  logic [3*ACC_BITS-1:0]         req_acc,
    output logic [X_BITS-BUCKET_BITS-1:0] tbl_idx,
    input  logic [FRAC_BITS+CMP_BITS-1:0] tbl_data,
    output logic                          rsp_valid,
    output logic [1:0]                    rsp_id,
    output logic [ACC_BITS-1:0]           rsp_acc,
    output logic                          busy
);

    logic [2:0]          w_grant;
    logic [1:0]          w_gnt_id;
    logic [X_BITS-1:0]   w_sel_coord;
    logic [ACC_BITS-1:0] w_sel_acc;

    logic                r_s1_valid;
    logic [1:0]          r_s1_id;
    logic [X_BITS-1:0]   r_s1_coord;
    logic [ACC_BITS-1:0] r_s1_acc;

    logic                r_rsp_valid;
    logic [1:0]          r_rsp_id;
    logic [ACC_BITS-1:0] r_rsp_acc;

    logic [FRAC_BITS-1:0] w_delta;
    logic [CMP_BITS-1:0]  w_cmp_val;
    logic                 w_ge;
    logic [ACC_BITS-1:0]  w_sum;

    field_rr_arbiter #(
        .STARVE_LIMIT_P (STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .grant     (w_grant)
    );

    always_comb begin
        w_gnt_id = REQ_LINE;
        if (w_grant[REQ_PIXEL])   w_gnt_id = REQ_PIXEL;
        else if (w_grant[REQ_BG]) w_gnt_id = REQ_BG;
    end

    assign w_sel_coord = req_coord[w_gnt_id*X_BITS +: X_BITS];
    assign w_sel_acc   = req_acc[w_gnt_id*ACC_BITS +: ACC_BITS];

    // Flush suppresses the grant, so S1 goes invalid on its own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_coord <= '0;
            r_s1_acc   <= '0;
        end else begin
            r_s1_valid <= |w_grant;
            if (|w_grant) begin
                r_s1_id    <= w_gnt_id;
                r_s1_coord <= w_sel_coord;
                r_s1_acc   <= w_sel_acc;
            end
        end
    end

    assign w_delta   = tbl_data[FRAC_BITS+CMP_BITS-1:CMP_BITS];
    assign w_cmp_val = tbl_data[CMP_BITS-1:0];
    assign w_ge      = (w_cmp_val >= bitrev(r_s1_coord[CMP_BITS-1:0]));
    assign w_sum     = r_s1_acc
                     + {{(ACC_BITS-FRAC_BITS){1'b0}}, w_delta}
                     + {{(ACC_BITS-1){1'b0}}, w_ge};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_acc   <= '0;
        end else begin
            r_rsp_valid <= r_s1_valid && !flush;
            if (r_s1_valid && !flush) begin
                r_rsp_id  <= r_s1_id;
                r_rsp_acc <= w_sum;
            end
        end
    end

    assign req_ready = w_grant;
    assign tbl_idx   = r_s1_coord[X_BITS-1:BUCKET_BITS];
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_acc   = r_rsp_acc;
    assign busy      = r_s1_valid | r_rsp_valid;

endmodule

// File: tb/tb_field_lookup_sched.sv
// Directed bench for field_lookup_sched: datapath arithmetic, arbitration,
// starvation forcing, flush and asynchronous reset.
module tb_field_lookup_sched;

    localparam int XB = 10;
    localparam int AB = 11;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [2:0]    req_valid;
    logic [2:0]    req_ready;
    logic [3*XB-1:0] req_coord;
    logic [3*AB-1:0] req_acc;
    logic [4:0]    tbl_idx;
    logic [6:0]    tbl_data;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [AB-1:0] rsp_acc;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    field_lookup_sched dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_coord (req_coord),
        .req_acc   (req_acc),
        .tbl_idx   (tbl_idx),
        .tbl_data  (tbl_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_acc   (rsp_acc),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [XB-1:0] c, input logic [AB-1:0] a);
        req_coord[i*XB +: XB] = c;
        req_acc[i*AB +: AB]   = a;
    endtask

    // Expected grant order once line drops out: pointer names background
    // at that point because the last shared grant went to pixel.
    logic [2:0] alt_exp [4] = '{3'b100, 3'b010, 3'b100, 3'b010};

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        req_valid = 3'b000;
        req_coord = '0;
        req_acc   = '0;
        tbl_data  = '0;
        #2 reset = 1'b1;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_tbl_idx",   32'(tbl_idx),   32'd0);
        check("rst_rsp_acc",   32'(rsp_acc),   32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Pixel request, compare false: 16 >= 24 is false -> 0x010 + 1
        set_req(1, 10'h003, 11'h010);
        req_valid = 3'b010;
        #1 check("single_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = 3'b000;
        tbl_data  = {2'd1, 5'd16};
        check("single_busy",    32'(busy),    32'd1);
        check("single_tbl_idx", 32'(tbl_idx), 32'h00);
        check("single_no_rsp",  32'(rsp_valid), 32'd0);
        tick();
        check("single_rsp_valid", 32'(rsp_valid), 32'd1);
        check("single_rsp_id",    32'(rsp_id),    32'd1);
        check("single_rsp_acc",   32'(rsp_acc),   32'h011);
        tick();
        check("single_rsp_drop", 32'(rsp_valid), 32'd0);
        check("single_idle",     32'(busy),      32'd0);

        // Line request, compare true with accumulator wrap: 0x7FF + 1 + 1
        set_req(0, 10'h3E0, 11'h7FF);
        req_valid = 3'b001;
        #1 check("wrap_ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = 3'b000;
        tbl_data  = {2'd1, 5'd16};
        check("wrap_tbl_idx", 32'(tbl_idx), 32'h1F);
        tick();
        check("wrap_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wrap_rsp_id",    32'(rsp_id),    32'd0);
        check("wrap_rsp_acc",   32'(rsp_acc),   32'h001);
        tick();

        // All three valid: line wins every cycle, pipeline runs back to back
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1 check($sformatf("arb_line_%0d", i), 32'(req_ready), 32'b001);
            tick();
        end
        check("arb_stream_valid", 32'(rsp_valid), 32'd1);
        check("arb_stream_id",    32'(rsp_id),    32'd0);
        req_valid = 3'b110;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("arb_alt_%0d", i), 32'(req_ready), 32'(alt_exp[i]));
            tick();
        end
        check("arb_alt_rsp_id", 32'(rsp_id), 32'd2);
        req_valid = 3'b000;
        tick();
        tick();
        check("arb_drain", 32'(busy), 32'd0);

        // Starvation: line and background held; background forced after 8 waits
        req_valid = 3'b101;
        for (int i = 0; i < 8; i++) begin
            #1 check($sformatf("starve_line_%0d", i), 32'(req_ready), 32'b001);
            tick();
        end
        #1 check("starve_forced_bg", 32'(req_ready), 32'b100);
        tick();
        #1 check("starve_back_line", 32'(req_ready), 32'b001);
        req_valid = 3'b000;
        tick();
        tick();
        tick();

        // Flush right after accepting a pixel request
        set_req(1, 10'h0A5, 11'h100);
        req_valid = 3'b010;
        #1 check("flush_accept", 32'(req_ready), 32'b010);
        tick();
        flush     = 1'b1;
        req_valid = 3'b100;
        #1 check("flush_no_grant", 32'(req_ready), 32'b000);
        check("flush_busy_s1", 32'(busy), 32'd1);
        tick();
        flush     = 1'b0;
        req_valid = 3'b000;
        check("flush_rsp_suppressed", 32'(rsp_valid), 32'd0);
        check("flush_idle",           32'(busy),      32'd0);
        tick();
        check("flush_still_quiet", 32'(rsp_valid), 32'd0);

        // Asynchronous reset while S1 is valid
        set_req(1, 10'h2A0, 11'h055);
        req_valid = 3'b010;
        tick();
        req_valid = 3'b000;
        check("midrst_busy_before", 32'(busy),    32'd1);
        check("midrst_idx_before",  32'(tbl_idx), 32'h15);
        #2 reset = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_tbl_idx",   32'(tbl_idx),   32'd0);
        #1 reset = 1'b0;
        req_valid = 3'b110;
        #1 check("midrst_rr_pixel", 32'(req_ready), 32'b010);
        tick();
        req_valid = 3'b000;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
